// File: rtl/t9990_vram_port_if.sv
// Backend memory bus for t9990_vram_port: 16-bit valid/ready command channel plus read-data return.
// master = VRAM port (issues beats), slave = board VRAM controller.
interface t9990_vram_port_if;
  logic        MEM_VALID;
  logic        MEM_READY;
  logic        MEM_WE;
  logic        MEM_RD;
  logic        MEM_RFSH;
  logic [17:0] MEM_ADDR;
  logic [15:0] MEM_WDATA;
  logic [1:0]  MEM_BE;
  logic        MEM_RVALID;
  logic [15:0] MEM_RDATA;
  logic        MEM_ERR;

  modport master (
    output MEM_VALID, MEM_WE, MEM_RD, MEM_RFSH, MEM_ADDR, MEM_WDATA, MEM_BE, MEM_ERR,
    input  MEM_READY, MEM_RVALID, MEM_RDATA
  );

  modport slave (
    input  MEM_VALID, MEM_WE, MEM_RD, MEM_RFSH, MEM_ADDR, MEM_WDATA, MEM_BE, MEM_ERR,
    output MEM_READY, MEM_RVALID, MEM_RDATA
  );
endinterface

// File: rtl/t9990_vram_port.sv
// VDP RAM responder: slot strobes, one command per slot, serviced as 16-bit backend beats.
// Optional per-beat stall abort enabled by defining T9990_VRAM_TIMEOUT_EN.
module t9990_vram_port #(
  parameter int unsigned SLOT_DIV = 4,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        CLK_21M_EN,
  output logic        RAM_REQ,
  input  logic        RAM_OE_n,
  input  logic        RAM_WE_n,
  input  logic        RAM_RFSH_n,
  input  logic [18:0] RAM_ADDR,
  input  logic [31:0] RAM_DIN,
  input  logic [1:0]  RAM_DIN_SIZE,
  output logic [31:0] RAM_DOUT,
  output logic        RAM_ACK_n,
  output logic        SLOT_MISS,
  t9990_vram_port_if.master mem
);

  typedef enum logic [2:0] {
    S_IDLE, S_B0, S_WAIT0, S_B1, S_WAIT1, S_RF, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  slot_cnt_q, slot_cnt_d;
  logic        slot_q, slot_d;
  logic        wr_q, wr_d;
  logic        byte_q, byte_d;
  logic [18:0] addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic [15:0] lo_q, lo_d;
  logic [31:0] dout_q, dout_d;
  logic [16:0] word;

  assign word = addr_q[18:2];

  // Slot pulse is registered so RAM_REQ/SLOT_MISS decode from flops only.
  always_comb begin
    slot_cnt_d = slot_cnt_q;
    slot_d     = 1'b0;
    if (CLK_21M_EN) begin
      if (slot_cnt_q == 4'(SLOT_DIV - 1)) begin
        slot_cnt_d = '0;
        slot_d     = 1'b1;
      end else begin
        slot_cnt_d = slot_cnt_q + 4'd1;
      end
    end
  end

  assign RAM_REQ   = slot_q && (state_q == S_IDLE);
  assign SLOT_MISS = slot_q && (state_q != S_IDLE);
  assign RAM_ACK_n = (state_q != S_DONE);
  assign RAM_DOUT  = dout_q;

`ifdef T9990_VRAM_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          stall, abort;

  always_comb begin
    stall = (((state_q == S_B0) || (state_q == S_B1) || (state_q == S_RF)) && !mem.MEM_READY) ||
            (((state_q == S_WAIT0) || (state_q == S_WAIT1)) && !mem.MEM_RVALID);
    abort = stall && (tmo_q == TW'(TIMEOUT - 1));
    tmo_d = (stall && !abort) ? tmo_q + 1'b1 : '0;
    err_d = abort;
  end

  assign mem.MEM_ERR = err_q;
`else
  assign mem.MEM_ERR = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    byte_d  = byte_q;
    addr_d  = addr_q;
    din_d   = din_q;
    lo_d    = lo_q;
    dout_d  = dout_q;
    case (state_q)
      S_IDLE: begin
        if (RAM_REQ) begin
          if (!RAM_WE_n || !RAM_OE_n) begin
            state_d = S_B0;
            wr_d    = !RAM_WE_n;
            byte_d  = (RAM_DIN_SIZE == 2'd0);
            addr_d  = RAM_ADDR;
            din_d   = RAM_DIN;
          end else if (!RAM_RFSH_n) begin
            state_d = S_RF;
          end
        end
      end
      S_B0: begin
        if (mem.MEM_READY) state_d = !wr_q ? S_WAIT0 : (byte_q ? S_DONE : S_B1);
      end
      S_WAIT0: begin
        if (mem.MEM_RVALID) begin
          lo_d    = mem.MEM_RDATA;
          state_d = S_B1;
        end
      end
      S_B1: begin
        if (mem.MEM_READY) state_d = wr_q ? S_DONE : S_WAIT1;
      end
      S_WAIT1: begin
        if (mem.MEM_RVALID) begin
          dout_d  = {mem.MEM_RDATA, lo_q};
          state_d = S_DONE;
        end
      end
      S_RF: begin
        if (mem.MEM_READY) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef T9990_VRAM_TIMEOUT_EN
    // Abort overrides any stalled beat; an aborted read reports all-ones data.
    if (abort) begin
      state_d = S_DONE;
      if (!wr_q && (state_q != S_RF)) dout_d = '1;
    end
`endif
  end

  always_comb begin
    mem.MEM_VALID = 1'b0;
    mem.MEM_WE    = 1'b0;
    mem.MEM_RD    = 1'b0;
    mem.MEM_RFSH  = 1'b0;
    mem.MEM_ADDR  = '0;
    mem.MEM_WDATA = '0;
    mem.MEM_BE    = '0;
    case (state_q)
      S_B0: begin
        mem.MEM_VALID = 1'b1;
        mem.MEM_WE    = wr_q;
        mem.MEM_RD    = !wr_q;
        if (wr_q && byte_q) begin
          mem.MEM_ADDR  = addr_q[18:1];
          mem.MEM_BE    = addr_q[0] ? 2'b10 : 2'b01;
          mem.MEM_WDATA = {din_q[7:0], din_q[7:0]};
        end else begin
          mem.MEM_ADDR  = {word, 1'b0};
          mem.MEM_BE    = 2'b11;
          mem.MEM_WDATA = wr_q ? din_q[15:0] : '0;
        end
      end
      S_B1: begin
        mem.MEM_VALID = 1'b1;
        mem.MEM_WE    = wr_q;
        mem.MEM_RD    = !wr_q;
        mem.MEM_ADDR  = {word, 1'b1};
        mem.MEM_BE    = 2'b11;
        mem.MEM_WDATA = wr_q ? din_q[31:16] : '0;
      end
      S_RF: begin
        mem.MEM_VALID = 1'b1;
        mem.MEM_RFSH  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q    <= S_IDLE;
      slot_cnt_q <= '0;
      slot_q     <= 1'b0;
      wr_q       <= 1'b0;
      byte_q     <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      lo_q       <= '0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      slot_cnt_q <= slot_cnt_d;
      slot_q     <= slot_d;
      wr_q       <= wr_d;
      byte_q     <= byte_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      lo_q       <= lo_d;
      dout_q     <= dout_d;
    end
  end

`ifdef T9990_VRAM_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_t9990_vram_port.sv
// Directed bench for t9990_vram_port: vector table of VDP commands against a scripted backend.
module tb_t9990_vram_port;
  logic        clk = 1'b0;
  logic        rst_n, en;
  logic        ram_req, oe_n, we_n, rfsh_n;
  logic [18:0] addr;
  logic [31:0] din;
  logic [1:0]  size;
  logic [31:0] dout;
  logic        ack_n, miss;

  always #5 clk = ~clk;

  t9990_vram_port_if mem_if ();

  t9990_vram_port #(.SLOT_DIV(4), .TIMEOUT(8)) dut (
    .CLK(clk), .RESET_n(rst_n), .CLK_21M_EN(en), .RAM_REQ(ram_req),
    .RAM_OE_n(oe_n), .RAM_WE_n(we_n), .RAM_RFSH_n(rfsh_n), .RAM_ADDR(addr),
    .RAM_DIN(din), .RAM_DIN_SIZE(size), .RAM_DOUT(dout), .RAM_ACK_n(ack_n),
    .SLOT_MISS(miss), .mem(mem_if)
  );

  typedef struct {
    logic we, oe, rf;
    logic [18:0] a;
    logic [31:0] d;
    logic [1:0]  sz;
    int          rwait, rdelay;
    logic [15:0] rd0, rd1;
    int          nb;
    logic [2:0]  t;
    logic [17:0] a0;
    logic [15:0] w0;
    logic [1:0]  be0;
    logic [17:0] a1;
    logic [15:0] w1;
    logic [1:0]  be1;
    int          lat, misses;
    logic [31:0] dout;
  } vec_t;

  int total = 0, bad = 0;
  int cyc = 0, req_cnt = 0, ack_cnt = 0, miss_cnt = 0, err_cnt = 0;
  int prev_req = -1, req_gap = 0;
  vec_t cur, vecs[10];
  bit pend = 0, issued = 0;
  int req_cyc, ack_cyc, m_snap, r_snap, a_snap, e_snap;
  logic [31:0] ack_dout;
  int nb, nrd, vcnt, rv_cnt;
  logic [15:0] rv_data;
  logic [2:0]  b_t[4];
  logic [17:0] b_a[4];
  logic [15:0] b_w[4];
  logic [1:0]  b_be[4];

  function automatic vec_t mk(logic we, logic oe, logic rf, logic [18:0] a, logic [31:0] d,
                              logic [1:0] sz, int rwait, int rdelay, logic [15:0] rd0,
                              logic [15:0] rd1, int nbt, logic [2:0] t, logic [17:0] a0,
                              logic [15:0] w0, logic [1:0] be0, logic [17:0] a1,
                              logic [15:0] w1, logic [1:0] be1, int lat, int misses,
                              logic [31:0] dv);
    vec_t v;
    v.we = we; v.oe = oe; v.rf = rf; v.a = a; v.d = d; v.sz = sz;
    v.rwait = rwait; v.rdelay = rdelay; v.rd0 = rd0; v.rd1 = rd1;
    v.nb = nbt; v.t = t; v.a0 = a0; v.w0 = w0; v.be0 = be0;
    v.a1 = a1; v.w1 = w1; v.be1 = be1; v.lat = lat; v.misses = misses; v.dout = dv;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One CLK: sample DUT at negedge, then drive requester and backend for the next posedge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!ack_n) begin ack_cnt++; ack_cyc = cyc; ack_dout = dout; end
    if (miss) miss_cnt++;
    if (mem_if.MEM_ERR) err_cnt++;
    if (ram_req) begin
      req_cnt++;
      if (prev_req >= 0) req_gap = cyc - prev_req;
      prev_req = cyc;
    end
    we_n = 1'b1; oe_n = 1'b1; rfsh_n = 1'b1;
    addr = '0; din = '0; size = '0;
    if (ram_req && pend) begin
      we_n = !cur.we; oe_n = !cur.oe; rfsh_n = !cur.rf;
      addr = cur.a; din = cur.d; size = cur.sz;
      pend = 0; issued = 1; req_cyc = cyc;
      m_snap = miss_cnt; r_snap = req_cnt; a_snap = ack_cnt; e_snap = err_cnt;
    end
    mem_if.MEM_RVALID = 1'b0;
    mem_if.MEM_RDATA  = 16'hDEAD;
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin mem_if.MEM_RVALID = 1'b1; mem_if.MEM_RDATA = rv_data; end
    end
    mem_if.MEM_READY = 1'b0;
    if (mem_if.MEM_VALID) begin
      if (vcnt >= cur.rwait) begin
        mem_if.MEM_READY = 1'b1;
        vcnt = 0;
        if (nb < 4) begin
          b_t[nb] = {mem_if.MEM_RFSH, mem_if.MEM_RD, mem_if.MEM_WE};
          b_a[nb] = mem_if.MEM_ADDR; b_w[nb] = mem_if.MEM_WDATA; b_be[nb] = mem_if.MEM_BE;
        end
        nb++;
        if (mem_if.MEM_RD) begin
          rv_cnt  = cur.rdelay;
          rv_data = (nrd == 0) ? cur.rd0 : cur.rd1;
          nrd++;
        end
      end else begin
        vcnt++;
      end
    end else begin
      vcnt = 0;
    end
  endtask

  task automatic start(input vec_t v);
    cur = v; pend = 1; issued = 0; nb = 0; nrd = 0; vcnt = 0; rv_cnt = 0;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    bit done;
    int k;
    start(v);
    done = 0;
    for (k = 0; k < 200 && !done; k++) begin
      tick();
      if (issued && !ack_n) done = 1;
    end
    chk($sformatf("v%0d_ack_seen", id), done, 1);
    if (done) begin
      chk($sformatf("v%0d_latency", id), ack_cyc - req_cyc, v.lat);
      chk($sformatf("v%0d_slot_miss", id), miss_cnt - m_snap, v.misses);
      chk($sformatf("v%0d_req_busy", id), req_cnt - r_snap, 0);
      chk($sformatf("v%0d_dout", id), ack_dout, v.dout);
      chk($sformatf("v%0d_nbeats", id), nb, v.nb);
      for (int i = 0; i < v.nb && i < nb; i++) begin
        chk($sformatf("v%0d_b%0d_type", id, i), b_t[i], v.t);
        if (v.t != 3'b100)
          chk($sformatf("v%0d_b%0d_addr", id, i), b_a[i], (i == 0) ? v.a0 : v.a1);
        if (v.t == 3'b001) begin
          chk($sformatf("v%0d_b%0d_wdata", id, i), b_w[i], (i == 0) ? v.w0 : v.w1);
          chk($sformatf("v%0d_b%0d_be", id, i), b_be[i], (i == 0) ? v.be0 : v.be1);
        end
      end
      repeat (3) tick();
      chk($sformatf("v%0d_ack_once", id), ack_cnt - a_snap, 1);
    end
  endtask

  initial begin
    int k, a0s, r0s, m0s;
    bit hit;
    vecs[0] = mk(1,0,0, 19'h00104, 32'hA5A5_1234, 2, 0,0, 0,0, 2, 3'b001,
                 18'h00082, 16'h1234, 2'b11, 18'h00083, 16'hA5A5, 2'b11, 3, 0, 32'h0);
    vecs[1] = mk(1,0,0, 19'h7C003, 32'hFFFF_FF5E, 0, 0,0, 0,0, 1, 3'b001,
                 18'h3E001, 16'h5E5E, 2'b10, 0, 0, 0, 2, 0, 32'h0);
    vecs[2] = mk(1,0,0, 19'h00006, 32'h0000_0033, 0, 2,0, 0,0, 1, 3'b001,
                 18'h00003, 16'h3333, 2'b01, 0, 0, 0, 4, 1, 32'h0);
    vecs[3] = mk(0,1,0, 19'h00020, 32'h0, 2, 0,1, 16'h0BAD,16'hF00D, 2, 3'b010,
                 18'h00010, 0, 0, 18'h00011, 0, 0, 5, 1, 32'hF00D_0BAD);
    vecs[4] = mk(1,0,0, 19'h00203, 32'hDEAD_BEEF, 1, 0,0, 0,0, 2, 3'b001,
                 18'h00100, 16'hBEEF, 2'b11, 18'h00101, 16'hDEAD, 2'b11, 3, 0, 32'hF00D_0BAD);
    vecs[5] = mk(0,0,1, 19'h0, 32'h0, 2, 0,0, 0,0, 1, 3'b100,
                 0, 0, 0, 0, 0, 0, 2, 0, 32'hF00D_0BAD);
    vecs[6] = mk(1,1,0, 19'h00008, 32'h1234_5678, 2, 0,0, 0,0, 2, 3'b001,
                 18'h00004, 16'h5678, 2'b11, 18'h00005, 16'h1234, 2'b11, 3, 0, 32'hF00D_0BAD);
    vecs[7] = mk(0,1,0, 19'h00010, 32'h0, 2, 0,3, 16'h1111,16'h2222, 2, 3'b010,
                 18'h00008, 0, 0, 18'h00009, 0, 0, 9, 2, 32'h2222_1111);
    vecs[8] = mk(0,1,0, 19'h00013, 32'h0, 0, 0,1, 16'h3333,16'h4444, 2, 3'b010,
                 18'h00008, 0, 0, 18'h00009, 0, 0, 5, 1, 32'h4444_3333);
    vecs[9] = mk(1,0,0, 19'h0000C, 32'h89AB_CDEF, 2, 1,0, 0,0, 2, 3'b001,
                 18'h00006, 16'hCDEF, 2'b11, 18'h00007, 16'h89AB, 2'b11, 5, 1, 32'h4444_3333);

    rst_n = 1'b0; en = 1'b1;
    we_n = 1'b1; oe_n = 1'b1; rfsh_n = 1'b1; addr = '0; din = '0; size = '0;
    mem_if.MEM_READY = 1'b0; mem_if.MEM_RVALID = 1'b0; mem_if.MEM_RDATA = '0;
    cur = vecs[0]; nb = 0; nrd = 0; vcnt = 0; rv_cnt = 0;
    repeat (3) tick();
    chk("rst_req", ram_req, 0);
    chk("rst_ack_n", ack_n, 1);
    chk("rst_dout", dout, 0);
    chk("rst_miss", miss, 0);
    chk("rst_mem_cmd", {mem_if.MEM_VALID, mem_if.MEM_WE, mem_if.MEM_RD, mem_if.MEM_RFSH, mem_if.MEM_ERR}, 0);
    chk("rst_mem_bus", {mem_if.MEM_ADDR, mem_if.MEM_WDATA, mem_if.MEM_BE}, 0);

    rst_n = 1'b1;
    repeat (4) tick();
    r0s = req_cnt; a0s = ack_cnt; m0s = miss_cnt;
    repeat (16) tick();
    chk("idle_req_count", req_cnt - r0s, 4);
    chk("idle_req_gap", req_gap, 4);
    chk("idle_no_ack", ack_cnt - a0s, 0);
    chk("idle_no_miss", miss_cnt - m0s, 0);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Reset asserted while the second read beat is outstanding.
    start(mk(0,1,0, 19'h00030, 32'h0, 2, 0,3, 16'h5555,16'h6666, 2, 3'b010,
             0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    hit = 0;
    for (k = 0; k < 100 && !hit; k++) begin
      tick();
      if (nb == 2) hit = 1;
    end
    chk("rstmid_reached_b1", hit, 1);
    tick();
    a0s = ack_cnt;
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", mem_if.MEM_VALID, 0);
    chk("rstmid_dout", dout, 0);
    tick();
    chk("rstmid_ack_n", ack_n, 1);
    chk("rstmid_req", {ram_req, miss}, 0);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("rstmid_no_ack", ack_cnt - a0s, 0);
    run_vec(10, vecs[0]);

`ifdef T9990_VRAM_TIMEOUT_EN
    run_vec(11, mk(0,1,0, 19'h00040, 32'h0, 2, 100000,1, 0,0, 0, 3'b010,
                   0, 0, 0, 0, 0, 0, 9, 2, 32'hFFFF_FFFF));
    chk("tmo_mem_err", err_cnt - e_snap, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
